// File: rtl/bp_me_fifo_aligned_pkg.sv
// Package: bp_me_fifo_aligned_pkg
//
// Purpose:
//   Shared definitions for the serialized 192-bit aligned BedRock memory
//   message used between the BedRock-to-FIFO endpoint and the host-side
//   memory responder. The message travels as six 32-bit words, word 0 first,
//   where word i occupies bits [32i+31:32i] of the aligned vector.
//
// Contents:
//   - Field bit offsets and message geometry constants
//   - BedRock msg_type / subop / size encodings
//   - Aligned message and payload packed structs
//   - Byte-lane helpers (rotation and access masks) for 32-bit words
//   - Responder FSM state encoding

package bp_me_fifo_aligned_pkg;

    // Field offsets are chained so the endpoint and responder can never
    // disagree on where one field ends and the next begins.
    localparam int msg_type_offset_gp = 0;
    localparam int subop_offset_gp    = msg_type_offset_gp + 8;
    localparam int addr_offset_gp     = subop_offset_gp + 8;
    localparam int size_offset_gp     = addr_offset_gp + 64;
    localparam int payload_offset_gp  = size_offset_gp + 8;
    localparam int data_offset_gp     = payload_offset_gp + 64;
    localparam int padding_offset_gp  = data_offset_gp + 32;

    localparam int aligned_msg_width_gp = padding_offset_gp + 8;
    localparam int aligned_msg_words_gp = 6;

    typedef enum logic [7:0] {
        e_bedrock_mem_rd    = 8'h00,
        e_bedrock_mem_wr    = 8'h01,
        e_bedrock_mem_uc_rd = 8'h02,
        e_bedrock_mem_uc_wr = 8'h03,
        e_bedrock_mem_pre   = 8'h04,
        e_bedrock_mem_amo   = 8'h05
    } bp_bedrock_mem_type_e;

    typedef enum logic [7:0] {
        e_bedrock_store   = 8'h00,
        e_bedrock_amolr   = 8'h01,
        e_bedrock_amosc   = 8'h02,
        e_bedrock_amoswap = 8'h03,
        e_bedrock_amoadd  = 8'h04,
        e_bedrock_amoxor  = 8'h05,
        e_bedrock_amoand  = 8'h06,
        e_bedrock_amoor   = 8'h07,
        e_bedrock_amomin  = 8'h08,
        e_bedrock_amomax  = 8'h09,
        e_bedrock_amominu = 8'h0a,
        e_bedrock_amomaxu = 8'h0b
    } bp_bedrock_wr_subop_e;

    typedef enum logic [7:0] {
        e_bedrock_msg_size_1  = 8'h00,
        e_bedrock_msg_size_2  = 8'h01,
        e_bedrock_msg_size_4  = 8'h02,
        e_bedrock_msg_size_8  = 8'h03,
        e_bedrock_msg_size_16 = 8'h04,
        e_bedrock_msg_size_32 = 8'h05,
        e_bedrock_msg_size_64 = 8'h06
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        logic [15:0] did;
        logic [15:0] lce_id;
        logic [15:0] way_id;
        logic [15:0] state;
    } bp_me_fifo_payload_s;

    typedef struct packed {
        logic [7:0]          padding;
        logic [31:0]         data;
        bp_me_fifo_payload_s payload;
        logic [7:0]          size;
        logic [63:0]         addr;
        logic [7:0]          subop;
        logic [7:0]          msg_type;
    } bp_me_fifo_aligned_msg_s;

    typedef enum logic [2:0] {
        e_state_rx,
        e_state_exec,
        e_state_resp,
        e_state_amo,
        e_state_tx
    } bp_me_fifo_responder_state_e;

    // Byte-enable for a 1/2/4-byte access at the given byte offset; size
    // codes above 4 bytes collapse to a full word. Lanes pushed past byte 3
    // are simply dropped.
    function automatic logic [3:0] access_byte_mask(input logic [7:0] size,
                                                    input logic [1:0] offset);
        logic [3:0] base_mask;
        logic [6:0] shifted;
        case (size)
            e_bedrock_msg_size_1: base_mask = 4'b0001;
            e_bedrock_msg_size_2: base_mask = 4'b0011;
            default:              base_mask = 4'b1111;
        endcase
        shifted = {3'b000, base_mask} << offset;
        return shifted[3:0];
    endfunction

    // Value mask for the access size, applied to AMO results so arithmetic
    // carries never leak into bytes outside the access.
    function automatic logic [31:0] access_value_mask(input logic [7:0] size);
        case (size)
            e_bedrock_msg_size_1: return 32'h0000_00ff;
            e_bedrock_msg_size_2: return 32'h0000_ffff;
            default:              return 32'hffff_ffff;
        endcase
    endfunction

    function automatic logic [31:0] rotl_bytes(input logic [31:0] value,
                                               input logic [1:0]  offset);
        case (offset)
            2'd1:    return {value[23:0], value[31:24]};
            2'd2:    return {value[15:0], value[31:16]};
            2'd3:    return {value[7:0],  value[31:8]};
            default: return value;
        endcase
    endfunction

    function automatic logic [31:0] rotr_bytes(input logic [31:0] value,
                                               input logic [1:0]  offset);
        case (offset)
            2'd1:    return {value[7:0],  value[31:8]};
            2'd2:    return {value[15:0], value[31:16]};
            2'd3:    return {value[23:0], value[31:24]};
            default: return value;
        endcase
    endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// Module: bsg_mem_1rw_sync_mask_write_byte
//
// Purpose:
//   Single-port synchronous RAM with per-byte write enables. A read issued
//   on one cycle presents its data on data_o the following cycle; data_o
//   holds until the next read. Contents are never reset.
//
// Ports:
//   clk_i         in   clock
//   v_i           in   access valid
//   w_i           in   1 = write, 0 = read
//   addr_i        in   word address
//   data_i        in   write data
//   write_mask_i  in   byte enables for writes
//   data_o        out  registered read data

module bsg_mem_1rw_sync_mask_write_byte #(
    parameter int  els_p               = 1024,
    parameter int  data_width_p        = 32,
    localparam int addr_width_lp       = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int write_mask_width_lp = data_width_p / 8
) (
    input  logic                           clk_i,
    input  logic                           v_i,
    input  logic                           w_i,
    input  logic [addr_width_lp-1:0]       addr_i,
    input  logic [data_width_p-1:0]        data_i,
    input  logic [write_mask_width_lp-1:0] write_mask_i,
    output logic [data_width_p-1:0]        data_o
);

    logic [data_width_p-1:0] mem [els_p];

    // One access per cycle: either a byte-masked write or a registered read.
    always_ff @(posedge clk_i) begin
        if (v_i) begin
            if (w_i) begin
                for (int b = 0; b < write_mask_width_lp; b++) begin
                    if (write_mask_i[b]) begin
                        mem[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                    end
                end
            end else begin
                data_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/bp_me_fifo_mem_responder.sv
// Module: bp_me_fifo_mem_responder
//
// Purpose:
//   Host-side memory model fed by the BedRock-to-FIFO endpoint. Collects a
//   six-word aligned memory message, executes it against an internal word
//   RAM, and for reads and AMOs streams back a six-word aligned response.
//   Stores are silent and only bump store_count_o. Only one message is in
//   flight; request words are accepted only while collecting.
//
// Ports:
//   clk_i                 in   clock
//   reset_n_i             in   synchronous active-low reset
//   fwd_fifo_i            in   request word stream
//   fwd_fifo_v_i          in   request word valid
//   fwd_fifo_ready_and_o  out  request word ready
//   rev_fifo_o            out  response word stream
//   rev_fifo_v_o          out  response word valid
//   rev_fifo_ready_and_i  in   response word ready
//   store_count_o         out  stores executed, wraps at 2^32
//   error_o               out  sticky error flag

module bp_me_fifo_mem_responder
    import bp_me_fifo_aligned_pkg::*;
#(
    parameter int          fifo_width_p = 32,
    parameter int          els_p        = 1024,
    parameter logic [63:0] base_addr_p  = 64'h0,
    localparam int         lg_els_lp    = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [fifo_width_p-1:0] fwd_fifo_i,
    input  logic                    fwd_fifo_v_i,
    output logic                    fwd_fifo_ready_and_o,
    output logic [fifo_width_p-1:0] rev_fifo_o,
    output logic                    rev_fifo_v_o,
    input  logic                    rev_fifo_ready_and_i,
    output logic [31:0]             store_count_o,
    output logic                    error_o
);

    bp_me_fifo_responder_state_e state_r, state_n;

    logic [2:0]                      word_cnt_r;
    logic [aligned_msg_width_gp-1:0] req_bits_r;
    logic [aligned_msg_width_gp-1:0] resp_bits_r;
    logic                            in_range_r;
    logic [31:0]                     store_count_r;
    logic                            error_r;

    bp_me_fifo_aligned_msg_s req;
    bp_me_fifo_aligned_msg_s resp_n;

    logic        fwd_hs, rev_hs, last_word;
    logic        is_store, is_read, is_amo, size_bad, in_range;
    logic [1:0]  offset;
    logic [61:0] diff_words;
    logic [31:0] old_word, new_word, resp_data;

    logic                 ram_v, ram_w;
    logic [lg_els_lp-1:0] ram_addr;
    logic [31:0]          ram_wdata, ram_rdata;
    logic [3:0]           ram_mask;
    logic                 resp_load, inc_store, set_error;

    assign req = req_bits_r;

    // Both handshake outputs are forced low while reset is held so nothing
    // transfers on a reset cycle regardless of the registered state.
    assign fwd_fifo_ready_and_o = reset_n_i && (state_r == e_state_rx);
    assign rev_fifo_v_o         = reset_n_i && (state_r == e_state_tx);
    assign fwd_hs               = fwd_fifo_v_i && fwd_fifo_ready_and_o;
    assign rev_hs               = rev_fifo_v_o && rev_fifo_ready_and_i;
    assign last_word            = (word_cnt_r == 3'(aligned_msg_words_gp - 1));

    assign rev_fifo_o    = resp_bits_r[{word_cnt_r, 5'b00000} +: fifo_width_p];
    assign store_count_o = store_count_r;
    assign error_o       = error_r;

    assign is_store = (req.msg_type == e_bedrock_mem_wr)
                   || (req.msg_type == e_bedrock_mem_uc_wr);
    assign is_read  = (req.msg_type == e_bedrock_mem_rd)
                   || (req.msg_type == e_bedrock_mem_uc_rd);
    assign is_amo   = (req.msg_type == e_bedrock_mem_amo);
    assign size_bad = (req.size > e_bedrock_msg_size_4);
    assign offset   = req.addr[1:0];

    // Word index relative to the RAM base. An address below the base wraps
    // to a huge index, but the explicit >= check rejects it anyway.
    assign diff_words = 62'((req.addr - base_addr_p) >> 2);
    assign in_range   = (req.addr >= base_addr_p) && (diff_words < 62'(els_p));
    assign ram_addr   = diff_words[lg_els_lp-1:0];

    // Out-of-range reads and AMOs never touched the RAM, so their "old"
    // value is defined as zero rather than whatever data_o last held.
    assign old_word = in_range_r ? rotr_bytes(ram_rdata, offset) : 32'h0;

    bsg_mem_1rw_sync_mask_write_byte #(
        .els_p        (els_p),
        .data_width_p (32)
    ) mem (
        .clk_i        (clk_i),
        .v_i          (ram_v && reset_n_i),
        .w_i          (ram_w),
        .addr_i       (ram_addr),
        .data_i       (ram_wdata),
        .write_mask_i (ram_mask),
        .data_o       (ram_rdata)
    );

    // Next-state and per-state actions: collect words, execute, capture the
    // read/AMO result into the response register, then stream it out.
    always_comb begin
        state_n   = state_r;
        ram_v     = 1'b0;
        ram_w     = 1'b0;
        ram_wdata = 32'h0;
        ram_mask  = 4'h0;
        resp_load = 1'b0;
        resp_data = 32'h0;
        inc_store = 1'b0;
        set_error = 1'b0;
        new_word  = old_word;

        case (state_r)
            e_state_rx: begin
                if (fwd_hs && last_word) begin
                    state_n = e_state_exec;
                end
            end
            e_state_exec: begin
                if (is_store) begin
                    inc_store = 1'b1;
                    set_error = size_bad || !in_range;
                    ram_v     = in_range;
                    ram_w     = 1'b1;
                    ram_wdata = rotl_bytes(req.data, offset);
                    ram_mask  = access_byte_mask(req.size, offset);
                    state_n   = e_state_rx;
                end else if (is_read || is_amo) begin
                    set_error = size_bad || !in_range;
                    ram_v     = in_range;
                    state_n   = is_amo ? e_state_amo : e_state_resp;
                end else begin
                    set_error = 1'b1;
                    state_n   = e_state_rx;
                end
            end
            e_state_resp: begin
                resp_data = old_word;
                resp_load = 1'b1;
                state_n   = e_state_tx;
            end
            e_state_amo: begin
                resp_data = old_word;
                resp_load = 1'b1;
                state_n   = e_state_tx;
                ram_w     = 1'b1;
                ram_mask  = access_byte_mask(req.size, offset);
                case (req.subop)
                    e_bedrock_amoswap: begin
                        new_word = req.data & access_value_mask(req.size);
                        ram_v    = in_range_r;
                    end
                    e_bedrock_amoadd: begin
                        new_word = (old_word + req.data) & access_value_mask(req.size);
                        ram_v    = in_range_r;
                    end
                    default: begin
                        set_error = 1'b1;
                    end
                endcase
                ram_wdata = rotl_bytes(new_word, offset);
            end
            e_state_tx: begin
                if (rev_hs && last_word) begin
                    state_n = e_state_rx;
                end
            end
            default: begin
                state_n = e_state_rx;
            end
        endcase

        resp_n         = req;
        resp_n.data    = resp_data;
        resp_n.padding = 8'h00;
    end

    // Control state: the only registers that reset. The shared word counter
    // indexes request slots in RX and response words in TX.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r       <= e_state_rx;
            word_cnt_r    <= 3'd0;
            store_count_r <= 32'h0;
            error_r       <= 1'b0;
        end else begin
            state_r <= state_n;
            if (fwd_hs || rev_hs) begin
                word_cnt_r <= last_word ? 3'd0 : word_cnt_r + 3'd1;
            end
            if (inc_store) begin
                store_count_r <= store_count_r + 32'h1;
            end
            if (set_error) begin
                error_r <= 1'b1;
            end
        end
    end

    // Message datapath; needs no reset because the FSM never reads a slot
    // that has not been refilled since reset.
    always_ff @(posedge clk_i) begin
        if (fwd_hs) begin
            req_bits_r[{word_cnt_r, 5'b00000} +: fifo_width_p] <= fwd_fifo_i;
        end
        if (state_r == e_state_exec) begin
            in_range_r <= in_range;
        end
        if (resp_load) begin
            resp_bits_r <= resp_n;
        end
    end

endmodule
